// File: rtl/uart_pkg.sv
// Shared UART constants: frame state encoding and parity-type selectors.
// Used by both the transmit framer and the receive side.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Request/line bundle between a word producer and the UART transmit framer.
// Handshake: a word is taken on a rising edge where DATA_VALID=1 and BUSY=0;
// DATA_VALID seen while BUSY=1 is dropped, never queued. state is debug only.
interface uart_tx_frame_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;
  state_t                state;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY, state
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY, state
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done for one cycle on the last count, then wraps.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign bit_done = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2
// stop bits. TX_OUT and BUSY come straight from flops so the line cannot glitch.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic CLK,
  input  logic RST,
  uart_tx_frame_if.slave bus
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  state_t                state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  bit_done;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  parity_bit;

  assign timer_clear = (state_q == IDLE);
  assign timer_en    = (state_q != IDLE);
  assign parity_bit  = (^data_q) ^ (par_typ_q == PAR_ODD);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .clear    (timer_clear),
    .enable   (timer_en),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      bit_idx   <= '0;
      data_q    <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          bit_idx <= '0;
          if (bus.DATA_VALID) begin
            data_q    <= bus.P_DATA;
            shift_q   <= bus.P_DATA;
            par_en_q  <= bus.PAR_EN;
            par_typ_q <= bus.PAR_TYP;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          // shift_q[0] is always the bit on the line; [1] is the next one.
          if (bit_done) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= parity_bit;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            bit_idx <= '0;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            if (bit_idx == LAST_STOP) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          bit_idx <= '0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = busy_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: two instances (1 and 2 stop bits) at 4 clocks/bit,
// checked cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(DW)) if1 ();
  uart_tx_frame_if #(.DATA_WIDTH(DW)) if2 ();

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .CLK(clk), .RST(rst), .bus(if1)
  );
  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RST(rst), .bus(if2)
  );

  int errors = 0;
  int checks = 0;

  logic [0:0] exp_q[$];
  logic cap_tx[0:255];
  logic cap_busy[0:255];
  logic even_seq[0:10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  // reference model: frame as a list of bit values, each CPB cycles wide
  task automatic model_frame(input logic [DW-1:0] d, input logic pen, input logic pt,
                             input int stops);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < DW; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_q.push_back(((ones % 2) == 1) ? ~pt : pt);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  function automatic logic exp_line(input int c);
    int b;
    b = c / CPB;
    if (b < exp_q.size()) return exp_q[b][0];
    return 1'b1;
  endfunction

  function automatic int frame_cycles();
    return exp_q.size() * CPB;
  endfunction

  // driver tasks
  task automatic drive(input int sel, input logic [DW-1:0] d, input logic pen,
                       input logic pt, input logic v);
    if (sel == 0) begin
      if1.P_DATA = d; if1.PAR_EN = pen; if1.PAR_TYP = pt; if1.DATA_VALID = v;
    end else begin
      if2.P_DATA = d; if2.PAR_EN = pen; if2.PAR_TYP = pt; if2.DATA_VALID = v;
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? if1.TX_OUT : if2.TX_OUT;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? if1.BUSY : if2.BUSY;
  endfunction

  // one-cycle DATA_VALID pulse; returns on the negedge of the first frame cycle
  task automatic send(input int sel, input logic [DW-1:0] d, input logic pen, input logic pt);
    @(negedge clk);
    drive(sel, d, pen, pt, 1'b1);
    @(negedge clk);
    drive(sel, d, pen, pt, 1'b0);
  endtask

  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[i]   = tx_of(sel);
      cap_busy[i] = busy_of(sel);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, '0, 1'b0, 1'b0, 1'b0);
    drive(1, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (if1.TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx1 got=%b exp=1", if1.TX_OUT); end
    checks++; if (if1.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", if1.BUSY); end
    checks++; if (if1.state !== IDLE) begin errors++; $display("FAIL reset_state1 got=%0d exp=%0d", if1.state, IDLE); end
    checks++; if (if2.TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx2 got=%b exp=1", if2.TX_OUT); end
    checks++; if (if2.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy2 got=%b exp=0", if2.BUSY); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_even_parity();
    int busy_n;
    send(0, 8'hA5, 1'b1, PAR_EVEN);
    capture(0, 52);
    model_frame(8'hA5, 1'b1, PAR_EVEN, 1);
    busy_n = 0;
    for (int c = 0; c < 52; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL even_tx c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c)); end
      checks++; if (cap_busy[c] !== (c < frame_cycles())) begin errors++; $display("FAIL even_busy c=%0d got=%b", c, cap_busy[c]); end
      busy_n += int'(cap_busy[c]);
    end
    for (int b = 0; b < 11; b++) begin
      checks++; if (cap_tx[b*CPB+2] !== even_seq[b]) begin errors++; $display("FAIL even_seq bit=%0d got=%b exp=%b", b, cap_tx[b*CPB+2], even_seq[b]); end
    end
    checks++; if (busy_n != 44) begin errors++; $display("FAIL even_busy_len got=%0d exp=44", busy_n); end
  endtask

  task automatic test_odd_parity();
    send(0, 8'hA5, 1'b1, PAR_ODD);
    capture(0, 52);
    model_frame(8'hA5, 1'b1, PAR_ODD, 1);
    for (int c = 0; c < 52; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL odd_tx c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c)); end
      checks++; if (cap_busy[c] !== (c < frame_cycles())) begin errors++; $display("FAIL odd_busy c=%0d got=%b", c, cap_busy[c]); end
    end
    checks++; if (cap_tx[9*CPB+1] !== 1'b1) begin errors++; $display("FAIL odd_parity_bit got=%b exp=1", cap_tx[9*CPB+1]); end
  endtask

  task automatic test_no_parity_two_stops();
    int busy_n;
    send(1, 8'h00, 1'b0, PAR_EVEN);
    capture(1, 50);
    model_frame(8'h00, 1'b0, PAR_EVEN, 2);
    busy_n = 0;
    for (int c = 0; c < 50; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL nopar_tx c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c)); end
      checks++; if (cap_busy[c] !== (c < frame_cycles())) begin errors++; $display("FAIL nopar_busy c=%0d got=%b", c, cap_busy[c]); end
      busy_n += int'(cap_busy[c]);
    end
    checks++; if (busy_n != 44) begin errors++; $display("FAIL nopar_busy_len got=%0d exp=44", busy_n); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int sel;
      int total;
      logic [DW-1:0] d;
      logic pen;
      logic pt;
      sel = int'($urandom_range(0, 1));
      d   = DW'($urandom_range(0, 255));
      pen = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      send(sel, d, pen, pt);
      model_frame(d, pen, pt, sel + 1);
      total = frame_cycles();
      capture(sel, total + 4);
      for (int c = 0; c < total + 4; c++) begin
        checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL rand_tx n=%0d d=%h c=%0d got=%b exp=%b", n, d, c, cap_tx[c], exp_line(c)); end
        checks++; if (cap_busy[c] !== (c < total)) begin errors++; $display("FAIL rand_busy n=%0d c=%0d got=%b", n, c, cap_busy[c]); end
      end
    end
  endtask

  task automatic test_mid_frame();
    send(0, 8'hA5, 1'b1, PAR_EVEN);
    for (int c = 0; c < 56; c++) begin
      cap_tx[c]   = if1.TX_OUT;
      cap_busy[c] = if1.BUSY;
      if (c == 10) drive(0, 8'h3C, 1'b0, PAR_ODD, 1'b1);
      if (c == 11) drive(0, 8'h3C, 1'b0, PAR_ODD, 1'b0);
      @(negedge clk);
    end
    model_frame(8'hA5, 1'b1, PAR_EVEN, 1);
    for (int c = 0; c < 56; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL mid_tx c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c)); end
      checks++; if (cap_busy[c] !== (c < frame_cycles())) begin errors++; $display("FAIL mid_busy c=%0d got=%b", c, cap_busy[c]); end
    end
  endtask

  task automatic test_back_to_back();
    int second_start;
    @(negedge clk);
    drive(0, 8'h55, 1'b0, PAR_EVEN, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 88; c++) begin
      cap_tx[c]   = if1.TX_OUT;
      cap_busy[c] = if1.BUSY;
      if (c == 10) drive(0, 8'h3C, 1'b0, PAR_EVEN, 1'b1);
      if (c == 41) drive(0, 8'h3C, 1'b0, PAR_EVEN, 1'b0);
      @(negedge clk);
    end
    model_frame(8'h55, 1'b0, PAR_EVEN, 1);
    for (int c = 0; c < 41; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL b2b_tx1 c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c)); end
      checks++; if (cap_busy[c] !== (c < 40)) begin errors++; $display("FAIL b2b_busy1 c=%0d got=%b", c, cap_busy[c]); end
    end
    model_frame(8'h3C, 1'b0, PAR_EVEN, 1);
    for (int c = 41; c < 88; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c - 41)) begin errors++; $display("FAIL b2b_tx2 c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c - 41)); end
      checks++; if (cap_busy[c] !== ((c - 41) < 40)) begin errors++; $display("FAIL b2b_busy2 c=%0d got=%b", c, cap_busy[c]); end
    end
    second_start = -1;
    for (int c = 37; c < 88; c++) begin
      if (second_start < 0 && cap_tx[c] === 1'b0) second_start = c;
    end
    checks++; if (second_start - 36 != 5) begin errors++; $display("FAIL b2b_gap got=%0d exp=5", second_start - 36); end
  endtask

  task automatic test_reset_mid();
    send(0, 8'hA5, 1'b1, PAR_EVEN);
    repeat (18) @(negedge clk);
    checks++; if (if1.state !== DATA) begin errors++; $display("FAIL rstmid_pre_state got=%0d exp=%0d", if1.state, DATA); end
    #1 rst = 1'b0;
    #1;
    checks++; if (if1.TX_OUT !== 1'b1) begin errors++; $display("FAIL rstmid_tx got=%b exp=1", if1.TX_OUT); end
    checks++; if (if1.BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", if1.BUSY); end
    checks++; if (if1.state !== IDLE) begin errors++; $display("FAIL rstmid_state got=%0d exp=%0d", if1.state, IDLE); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(0, 8'hA5, 1'b1, PAR_EVEN);
    capture(0, 48);
    model_frame(8'hA5, 1'b1, PAR_EVEN, 1);
    for (int c = 0; c < 48; c++) begin
      checks++; if (cap_tx[c] !== exp_line(c)) begin errors++; $display("FAIL rstmid_tx2 c=%0d got=%b exp=%b", c, cap_tx[c], exp_line(c)); end
      checks++; if (cap_busy[c] !== (c < frame_cycles())) begin errors++; $display("FAIL rstmid_busy2 c=%0d got=%b", c, cap_busy[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity_two_stops();
    test_mid_frame();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
